// File: rtl/aes256_pkg.sv
// Shared AES-256 constants, controller state encoding and byte/word transforms
// (S-box, SubWord, RotWord, Rcon) used by key expansion and the round core.
package aes256_pkg;

    localparam int unsigned KEY_W  = 256;
    localparam int unsigned RK_W   = 128;
    localparam int unsigned NUM_RK = 15;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_READY  = 2'd2
    } state_t;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [2047:0] sh;
        sh = SBOX_TBL << (11'(b) * 11'd8);
        return sh[2047:2040];
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Rcon byte for the even round-key slots 2..14.
    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] cnt);
        logic [7:0] r;
        case (cnt)
            4'd2:    r = 8'h01;
            4'd4:    r = 8'h02;
            4'd6:    r = 8'h04;
            4'd8:    r = 8'h08;
            4'd10:   r = 8'h10;
            4'd12:   r = 8'h20;
            4'd14:   r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes256_rk_step.sv
// Combinational AES-256 key-expansion step: produces the next 128-bit round key
// from the sliding 256-bit window of the previous eight words.
module aes256_rk_step
    import aes256_pkg::*;
(
    input  logic [KEY_W-1:0] window,
    input  logic             odd,
    input  logic [7:0]       rcon_byte,
    output logic [RK_W-1:0]  next_rk_c
);

    logic [WORD_W-1:0] sw_in;
    logic [WORD_W-1:0] temp;
    logic [WORD_W-1:0] n0, n1, n2, n3;

    // Odd slots skip RotWord and Rcon, so one S-box row serves both cases.
    always_comb begin
        sw_in     = odd ? window[31:0] : rot_word(window[31:0]);
        temp      = sub_word(sw_in) ^ (odd ? 32'h0 : {rcon_byte, 24'h0});
        n0        = window[255:224] ^ temp;
        n1        = window[223:192] ^ n0;
        n2        = window[191:160] ^ n1;
        n3        = window[159:128] ^ n2;
        next_rk_c = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes256_rk_sched_ctrl.sv
// AES-256 round-key schedule controller: accepts a key, expands one round key per
// cycle into a 15-entry buffer, serves keys by index. Option: AES_KEY_ZEROIZE_EN.
module aes256_rk_sched_ctrl
    import aes256_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key,
    input  logic             rk_req,
    input  logic [IDX_W-1:0] rk_idx,
    output logic [RK_W-1:0]  rk_out,
    output logic             rk_valid,
    output logic             keys_ready,
    output logic             busy
`ifdef AES_KEY_ZEROIZE_EN
    ,
    input  logic             zeroize
`endif
);

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [KEY_W-1:0]  window;
    logic [RK_W-1:0]   rk_mem [NUM_RK];
    logic [RK_W-1:0]   next_rk_c;
    logic              ctl_clr_c;
    logic              accept_c;
    logic              read_ok_c;

`ifdef AES_KEY_ZEROIZE_EN
    assign ctl_clr_c = rst | zeroize;
`else
    assign ctl_clr_c = rst;
`endif

    assign accept_c  = key_valid & key_ready;
    assign read_ok_c = rk_req & (state == S_READY) & (rk_idx <= IDX_W'(NUM_RK - 1));

    aes256_rk_step u_step (
        .window    (window),
        .odd       (cnt[0]),
        .rcon_byte (rcon(cnt)),
        .next_rk_c (next_rk_c)
    );

    // Control FSM and read port; flags are registered alongside the state.
    always_ff @(posedge clk) begin
        if (ctl_clr_c) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rk_out     <= '0;
            rk_valid   <= 1'b0;
            key_ready  <= 1'b1;
            keys_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rk_valid <= read_ok_c;
            if (read_ok_c) begin
                rk_out <= rk_mem[rk_idx];
            end
            case (state)
                S_IDLE, S_READY: begin
                    if (accept_c) begin
                        state      <= S_EXPAND;
                        cnt        <= IDX_W'(2);
                        key_ready  <= 1'b0;
                        keys_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_EXPAND: begin
                    if (cnt == IDX_W'(NUM_RK - 1)) begin
                        state      <= S_READY;
                        key_ready  <= 1'b1;
                        keys_ready <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    key_ready  <= 1'b1;
                    keys_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Key buffer and expansion window; only a wipe clears key material.
    always_ff @(posedge clk) begin
        if (ctl_clr_c) begin
`ifdef AES_KEY_ZEROIZE_EN
            window <= '0;
            for (int i = 0; i < NUM_RK; i++) begin
                rk_mem[i] <= '0;
            end
`endif
        end else if (accept_c) begin
            rk_mem[0] <= key[255:128];
            rk_mem[1] <= key[127:0];
            window    <= key;
        end else if (state == S_EXPAND) begin
            rk_mem[cnt] <= next_rk_c;
            window      <= {window[127:0], next_rk_c};
        end
    end

endmodule

// File: tb/tb_aes256_rk_sched_ctrl.sv
// Scoreboard bench for aes256_rk_sched_ctrl: reads push expected keys, a negedge
// monitor pops and compares on rk_valid. Expected schedule from a GF(2^8) model.
module tb_aes256_rk_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_valid;
    logic         keys_ready;
    logic         busy;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] exp_q  [$];
    string        name_q [$];
    logic [7:0]   sb [256];

    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K2 = 256'h642423ba0f1e2d3c4b5a69788796a5b4c3d2e1f011223344556677889c9b5a30;
    localparam logic [127:0] RK1_HAND  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RK2_HAND  = 128'ha573c29fa176c498a97fce93a572c09c;
    localparam logic [127:0] RK14_HAND = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    always #5 clk = ~clk;

    aes256_rk_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .rk_req     (rk_req),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .rk_valid   (rk_valid),
        .keys_ready (keys_ready),
        .busy       (busy)
`ifdef AES_KEY_ZEROIZE_EN
        ,
        .zeroize    (zeroize)
`endif
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box rebuilt from first principles: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_rk(input logic [255:0] k, input int idx);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0};
            end else if (i % 8 == 4) begin
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            end
            w[i] = w[i-8] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int idx, input logic [127:0] exp, input string nm);
        rk_req = 1'b1;
        rk_idx = 4'(idx);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        tick();
        rk_req = 1'b0;
    endtask

    // Call just after the accept edge; returns right after the edge entering READY.
    task automatic expand_wait(input string nm);
        logic ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (keys_ready !== 1'b0 || busy !== 1'b1 || key_ready !== 1'b0 || rk_valid !== 1'b0) ok = 1'b0;
        end
        check({nm, "_expand_flags"}, 128'(ok), 128'd1);
        tick();
        check({nm, "_keys_ready_at_14"}, 128'({keys_ready, busy, key_ready}), 128'(3'b101));
    endtask

    task automatic read_all(input logic [255:0] k, input string nm);
        for (int i = 0; i < 15; i++) begin
            rd(i, model_rk(k, i), $sformatf("%s_rk%0d", nm, i));
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rk_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rk_valid: got rk_out %h with no read outstanding", rk_out);
            end else begin
                logic [127:0] e;
                string        nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, rk_out, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) sb[i] = sbox_ref(8'(i));
        rst = 1'b1; key_valid = 1'b0; key = '0; rk_req = 1'b0; rk_idx = '0;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        check("reset_key_ready", 128'(key_ready), 128'd1);
        check("reset_flags", 128'({keys_ready, busy, rk_valid}), 128'd0);
        check("reset_rk_out", rk_out, 128'd0);

        // read before any key: no response
        rk_req = 1'b1; rk_idx = 4'd0;
        tick();
        rk_req = 1'b0;
        check("idle_read_no_valid", 128'(rk_valid), 128'd0);

        // FIPS-197 key, read requested throughout expansion
        key = K1; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check("accept_busy", 128'({busy, key_ready, keys_ready}), 128'(3'b100));
        rk_req = 1'b1; rk_idx = 4'd0;
        expand_wait("k1");
        rk_req = 1'b0;

        // back-to-back read of the whole schedule; hand values where known
        rd(0, K1[255:128], "k1_rk0_hand");
        rd(1, RK1_HAND, "k1_rk1_hand");
        rd(2, RK2_HAND, "k1_rk2_hand");
        for (int i = 3; i < 14; i++) rd(i, model_rk(K1, i), $sformatf("k1_rk%0d", i));
        rd(14, RK14_HAND, "k1_rk14_hand");
        check("model_rk14_vs_hand", model_rk(K1, 14), RK14_HAND);
        rk_req = 1'b1; rk_idx = 4'd15;
        tick();
        rk_req = 1'b0;
        check("idx15_no_valid", 128'(rk_valid), 128'd0);
        check("idx15_rk_out_holds", rk_out, RK14_HAND);

        // rekey in READY with a same-cycle read served from the old schedule
        key = K2; key_valid = 1'b1;
        rk_req = 1'b1; rk_idx = 4'd14;
        exp_q.push_back(RK14_HAND); name_q.push_back("rekey_cycle_read_old");
        tick();
        rk_req = 1'b0;
        check("rekey_keys_ready_drop", 128'({keys_ready, busy}), 128'(2'b01));
        key = K1;                       // next key held valid during expansion
        expand_wait("k2");
        rk_req = 1'b1; rk_idx = 4'd0;   // READY cycle: held key accepted, read still K2
        exp_q.push_back(K2[255:128]); name_q.push_back("k2_rk0_hand");
        tick();
        rk_req = 1'b0; key_valid = 1'b0;
        check("held_key_accepted_at_ready", 128'({busy, key_ready}), 128'(2'b10));

        // reset mid-expansion at cnt=7
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_flags", 128'({key_ready, keys_ready, busy, rk_valid}), 128'(4'b1000));
        check("midrst_rk_out", rk_out, 128'd0);

        // fresh load after abort
        key = K2; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        expand_wait("k2b");
        read_all(K2, "k2");

`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b1; key = K1; key_valid = 1'b1; rk_req = 1'b1; rk_idx = 4'd0;
        tick();
        zeroize = 1'b0; key_valid = 1'b0; rk_req = 1'b0;
        check("zeroize_flags", 128'({key_ready, keys_ready, busy, rk_valid}), 128'(4'b1000));
        check("zeroize_rk_out", rk_out, 128'd0);
`endif

        tick();
        tick();
        check("scoreboard_drain", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
